// File: rtl/imm_alu_dmem_pkg.sv
// Shared constants for the RV32I execute/memory datapath core.
// Covers ALU operation codes, opcodes, and the branch and memory funct3 encodings.
package imm_alu_dmem_pkg;

  localparam int ALU_W     = 32;
  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W    = 6;

  localparam logic [3:0] ALUSEL_ADD   = 4'b0000;
  localparam logic [3:0] ALUSEL_SUB   = 4'b0001;
  localparam logic [3:0] ALUSEL_XOR   = 4'b0011;
  localparam logic [3:0] ALUSEL_OR    = 4'b0100;
  localparam logic [3:0] ALUSEL_PASSB = 4'b0101;
  localparam logic [3:0] ALUSEL_AND   = 4'b0111;
  localparam logic [3:0] ALUSEL_SRL   = 4'b1000;
  localparam logic [3:0] ALUSEL_SLL   = 4'b1001;
  localparam logic [3:0] ALUSEL_SRA   = 4'b1010;
  localparam logic [3:0] ALUSEL_SLT   = 4'b1101;
  localparam logic [3:0] ALUSEL_SLTU  = 4'b1111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/imm_alu_dmem_if.sv
// Bundle of every datapath signal between the pipeline and this core.
// The master side drives the operands and controls, and the slave side returns the results.
interface imm_alu_dmem_if import imm_alu_dmem_pkg::*; #(parameter int N = ALU_W);

  logic [31:0]       inst;
  logic [31:0]       gen_out;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic [3:0]        alusel;
  logic [4:0]        shamt;
  logic [2:0]        funct3;
  logic [N-1:0]      r;
  logic              cf;
  logic              zf;
  logic              vf;
  logic              sf;
  logic              branch_taken;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;

  modport master (
    output inst, a, b, alusel, shamt, funct3, MemRead, MemWrite, addr, data_in,
    input  gen_out, r, cf, zf, vf, sf, branch_taken, data_out
  );

  modport slave (
    input  inst, a, b, alusel, shamt, funct3, MemRead, MemWrite, addr, data_in,
    output gen_out, r, cf, zf, vf, sf, branch_taken, data_out
  );

endinterface

// File: rtl/imm_alu_dmem_add_sub_unit.sv
// Shared N-bit adder that computes a+b, or a-b when sub is set.
// The ALU flags come from this adder, so cf reports "no borrow" when subtracting.
module add_sub_unit #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cf,
  output logic         vf
);

  logic [N-1:0] b_op;
  logic [N:0]   full;

  assign b_op = sub ? ~b : b;
  assign full = {1'b0, a} + {1'b0, b_op} + {{N{1'b0}}, sub};
  assign sum  = full[N-1:0];
  assign cf   = full[N];
  assign vf   = (a[N-1] == b_op[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/imm_alu_dmem_alu_core.sv
// 32-bit ALU with adder-derived flags and a branch resolver.
// The branch resolver compares a and b on its own, so its result does not depend on alusel.
module alu_core import imm_alu_dmem_pkg::*; #(parameter int N = ALU_W) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alusel,
  input  logic [2:0]   funct3,
  output logic [N-1:0] r,
  output logic         cf,
  output logic         zf,
  output logic         vf,
  output logic         sf,
  output logic         branch_taken
);

  localparam int SH_W = $clog2(N);

  logic [N-1:0]    sum;
  logic            sub;
  logic [SH_W-1:0] sh;

  assign sub = (alusel != ALUSEL_ADD);
  assign sh  = b[SH_W-1:0];
  assign zf  = (sum == '0);
  assign sf  = sum[N-1];

  add_sub_unit #(.N(N)) u_add_sub (
    .a   (a),
    .b   (b),
    .sub (sub),
    .sum (sum),
    .cf  (cf),
    .vf  (vf)
  );

  always_comb begin
    r = '0;
    case (alusel)
      ALUSEL_ADD, ALUSEL_SUB: r = sum;
      ALUSEL_XOR:   r = a ^ b;
      ALUSEL_OR:    r = a | b;
      ALUSEL_AND:   r = a & b;
      ALUSEL_PASSB: r = b;
      ALUSEL_SRL:   r = a >> sh;
      ALUSEL_SLL:   r = a << sh;
      ALUSEL_SRA:   r = $signed(a) >>> sh;
      ALUSEL_SLT:   r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUSEL_SLTU:  r = {{(N-1){1'b0}}, (a < b)};
      default:      r = '0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      BR_EQ:   branch_taken = (a == b);
      BR_NE:   branch_taken = (a != b);
      BR_LT:   branch_taken = ($signed(a) < $signed(b));
      BR_GE:   branch_taken = ($signed(a) >= $signed(b));
      BR_LTU:  branch_taken = (a < b);
      BR_GEU:  branch_taken = (a >= b);
      default: branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_alu_dmem_data_mem_core.sv
// Word-addressed data memory that supports byte, halfword, and word stores and loads.
// Reset clears the whole array asynchronously, and loads are read combinationally from the addressed word.
module data_mem_core import imm_alu_dmem_pkg::*; #(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out
);

  logic [31:0] mem [DEPTH];
  logic [31:0] word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write) begin
      case (funct3)
        MEM_B:   mem[addr][7:0]  <= data_in[7:0];
        MEM_H:   mem[addr][15:0] <= data_in[15:0];
        MEM_W:   mem[addr]       <= data_in;
        default: ;
      endcase
    end
  end

  assign word = mem[addr];

  always_comb begin
    data_out = '0;
    if (mem_read) begin
      case (funct3)
        MEM_B:   data_out = {{24{word[7]}}, word[7:0]};
        MEM_BU:  data_out = {24'b0, word[7:0]};
        MEM_H:   data_out = {{16{word[15]}}, word[15:0]};
        MEM_HU:  data_out = {16'b0, word[15:0]};
        MEM_W:   data_out = word;
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: rtl/imm_alu_dmem_imm_gen.sv
// Immediate generator that sign-extends the immediate field selected by the opcode.
// The B-format immediate is kept halfword-scaled, so the branch target adder applies the shift.
module imm_gen import imm_alu_dmem_pkg::*; (
  input  logic [31:0] inst,
  output logic [31:0] gen_out
);

  always_comb begin
    gen_out = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: gen_out = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 gen_out = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                gen_out = {{20{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8]};
      OP_LUI, OP_AUIPC:         gen_out = {inst[31:12], 12'b0};
      OP_JAL:                   gen_out = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  gen_out = '0;
    endcase
  end

endmodule

// File: rtl/imm_alu_dmem.sv
// Top level of the execute/memory core, which wires the immediate, ALU, and memory units to the bus.
// The shamt field is unused because the shift amount always comes from b.
module imm_alu_dmem import imm_alu_dmem_pkg::*; #(
  parameter int N     = ALU_W,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  imm_alu_dmem_if.slave  bus
);

  imm_gen u_imm_gen (
    .inst    (bus.inst),
    .gen_out (bus.gen_out)
  );

  alu_core #(.N(N)) u_alu_core (
    .a            (bus.a),
    .b            (bus.b),
    .alusel       (bus.alusel),
    .funct3       (bus.funct3),
    .r            (bus.r),
    .cf           (bus.cf),
    .zf           (bus.zf),
    .vf           (bus.vf),
    .sf           (bus.sf),
    .branch_taken (bus.branch_taken)
  );

  data_mem_core #(.DEPTH(DEPTH), .AW(ADDR_W)) u_data_mem_core (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (bus.MemRead),
    .mem_write (bus.MemWrite),
    .funct3    (bus.funct3),
    .addr      (bus.addr),
    .data_in   (bus.data_in),
    .data_out  (bus.data_out)
  );

endmodule

// File: tb/tb_imm_alu_dmem.sv
// Self-checking bench for imm_alu_dmem, using vector tables, directed memory sequences, and random runs against a behavioural model.
module tb_imm_alu_dmem;

  logic clk;
  logic rst;
  int   numChecks;
  int   numFails;
  logic [31:0] modelMem [64];

  imm_alu_dmem_if #(.N(32)) bus ();

  imm_alu_dmem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
  } imm_vec_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [31:0] r;
    logic        cf;
    logic        zf;
    logic        vf;
    logic        sf;
    logic        br;
  } alu_vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural ALU reference, written from the arithmetic meaning of each operation
  function automatic logic [31:0] refAlu(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y & 32'd31;
    case (sel)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0011: return x ^ y;
      4'b0100: return x | y;
      4'b0111: return x & y;
      4'b0101: return y;
      4'b1000: return x >> sh;
      4'b1001: return x << sh;
      4'b1010: return $signed(x) >>> sh;
      4'b1101: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1111: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] refFlags(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sres;
    logic [31:0] res;
    logic cfl, vfl;
    sx = $signed(x);
    sy = $signed(y);
    if (sel == 4'b0000) begin
      res  = x + y;
      cfl  = ({32'b0, x} + {32'b0, y}) > 64'h0000_0000_FFFF_FFFF;
      sres = sx + sy;
    end else begin
      res  = x - y;
      cfl  = (x >= y);
      sres = sx - sy;
    end
    vfl = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {cfl, (res == 32'd0), vfl, res[31]};
  endfunction

  function automatic logic refBranch(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] refLoad(input logic rd, input logic [2:0] f3, input logic [31:0] w);
    if (!rd) return 32'd0;
    case (f3)
      3'b000: return {{24{w[7]}}, w[7:0]};
      3'b100: return {24'b0, w[7:0]};
      3'b001: return {{16{w[15]}}, w[15:0]};
      3'b101: return {16'b0, w[15:0]};
      3'b010: return w;
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] f3, input logic [5:0] ad, input logic [31:0] d);
    @(negedge clk);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.funct3   = f3;
    bus.addr     = ad;
    bus.data_in  = d;
    @(posedge clk);
    #1 bus.MemWrite = 1'b0;
  endtask

  task automatic checkLoad(input string name, input logic rd, input logic [2:0] f3,
                           input logic [5:0] ad, input logic [31:0] exp);
    bus.MemRead = rd;
    bus.funct3  = f3;
    bus.addr    = ad;
    #1 checkOutput(name, bus.data_out, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    imm_vec_t immTab[7];
    alu_vec_t aluTab[7];
    logic [3:0] fl;
    logic [31:0] ra, rb, d;
    logic [3:0] sel;
    logic [2:0] f3;
    logic [5:0] ad;
    logic rd;

    numChecks = 0;
    numFails  = 0;
    rst = 1'b0;
    bus.inst = '0; bus.a = '0; bus.b = '0; bus.alusel = '0; bus.shamt = '0;
    bus.funct3 = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.addr = '0; bus.data_in = '0;

    #2 checkLoad("reset_load", 1'b1, 3'b010, 6'd0, 32'd0);
    #10 rst = 1'b1;

    immTab[0] = '{32'hFFF00093, 32'hFFFFFFFF};
    immTab[1] = '{32'h00000463, 32'h00000004};
    immTab[2] = '{32'h123450B7, 32'h12345000};
    immTab[3] = '{32'h0020A423, 32'h00000008};
    immTab[4] = '{32'h0010006F, 32'h00000800};
    immTab[5] = '{32'h8000006F, 32'hFFF00000};
    immTab[6] = '{32'h00000033, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      bus.inst = immTab[i].inst;
      #1 checkOutput($sformatf("imm[%0d]", i), bus.gen_out, immTab[i].imm);
    end

    aluTab[0] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    aluTab[1] = '{4'b0001, 32'h00000005, 32'h00000005, 3'b000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    aluTab[2] = '{4'b1010, 32'h80000000, 32'h00000004, 3'b001, 32'hF8000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    aluTab[3] = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    aluTab[4] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    aluTab[5] = '{4'b0010, 32'h00000003, 32'h00000004, 3'b010, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    aluTab[6] = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      bus.alusel = aluTab[i].sel;
      bus.a      = aluTab[i].a;
      bus.b      = aluTab[i].b;
      bus.funct3 = aluTab[i].f3;
      #1;
      checkOutput($sformatf("alu_r[%0d]", i),  bus.r,                   aluTab[i].r);
      checkOutput($sformatf("alu_cf[%0d]", i), {31'b0, bus.cf},         {31'b0, aluTab[i].cf});
      checkOutput($sformatf("alu_zf[%0d]", i), {31'b0, bus.zf},         {31'b0, aluTab[i].zf});
      checkOutput($sformatf("alu_vf[%0d]", i), {31'b0, bus.vf},         {31'b0, aluTab[i].vf});
      checkOutput($sformatf("alu_sf[%0d]", i), {31'b0, bus.sf},         {31'b0, aluTab[i].sf});
      checkOutput($sformatf("alu_br[%0d]", i), {31'b0, bus.branch_taken}, {31'b0, aluTab[i].br});
    end

    for (int i = 0; i < 300; i++) begin
      sel = 4'($urandom_range(0, 15));
      f3  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      bus.alusel = sel;
      bus.a      = ra;
      bus.b      = rb;
      bus.funct3 = f3;
      bus.shamt  = 5'($urandom);
      #1;
      fl = refFlags(sel, ra, rb);
      checkOutput("rnd_r",  bus.r, refAlu(sel, ra, rb));
      checkOutput("rnd_flags", {28'b0, bus.cf, bus.zf, bus.vf, bus.sf}, {28'b0, fl});
      checkOutput("rnd_br", {31'b0, bus.branch_taken}, {31'b0, refBranch(f3, ra, rb)});
    end

    applyStimulus(3'b010, 6'd3, 32'h80FF7F01);
    checkLoad("lw_after_sw",  1'b1, 3'b010, 6'd3, 32'h80FF7F01);
    checkLoad("lb_after_sw",  1'b1, 3'b000, 6'd3, 32'h00000001);
    checkLoad("lh_after_sw",  1'b1, 3'b001, 6'd3, 32'h00007F01);
    checkLoad("lbu_after_sw", 1'b1, 3'b100, 6'd3, 32'h00000001);
    checkLoad("ld_f3_011",    1'b1, 3'b011, 6'd3, 32'h00000000);
    applyStimulus(3'b001, 6'd3, 32'h12348001);
    checkLoad("lhu_after_sh", 1'b1, 3'b101, 6'd3, 32'h00008001);
    checkLoad("lh_after_sh",  1'b1, 3'b001, 6'd3, 32'hFFFF8001);
    checkLoad("lw_after_sh",  1'b1, 3'b010, 6'd3, 32'h80FF8001);
    applyStimulus(3'b000, 6'd3, 32'hAAAAAA80);
    checkLoad("lb_after_sb",  1'b1, 3'b000, 6'd3, 32'hFFFFFF80);
    checkLoad("lbu_after_sb", 1'b1, 3'b100, 6'd3, 32'h00000080);
    applyStimulus(3'b011, 6'd3, 32'h55555555);
    checkLoad("st_f3_011_nop", 1'b1, 3'b010, 6'd3, 32'h80FF8080);
    checkLoad("read_disable",  1'b0, 3'b010, 6'd3, 32'h00000000);
    checkLoad("addr_4_untouched", 1'b1, 3'b010, 6'd4, 32'h00000000);

    // Reading while storing: the old word is visible until the write edge.
    @(negedge clk);
    bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.funct3 = 3'b010;
    bus.addr = 6'd3; bus.data_in = 32'h11111111;
    #1 checkOutput("rw_before_edge", bus.data_out, 32'h80FF8080);
    @(posedge clk);
    #1 checkOutput("rw_after_edge", bus.data_out, 32'h11111111);
    bus.MemWrite = 1'b0;

    applyStimulus(3'b010, 6'd5, 32'hDEADBEEF);
    checkLoad("lw_addr5", 1'b1, 3'b010, 6'd5, 32'hDEADBEEF);
    @(posedge clk);
    #3 rst = 1'b0;
    checkLoad("async_clear_5", 1'b1, 3'b010, 6'd5, 32'h00000000);
    checkLoad("async_clear_3", 1'b1, 3'b010, 6'd3, 32'h00000000);
    applyStimulus(3'b010, 6'd5, 32'hCAFEF00D);
    checkLoad("write_in_reset", 1'b1, 3'b010, 6'd5, 32'h00000000);
    @(negedge clk) rst = 1'b1;
    checkLoad("after_release", 1'b1, 3'b010, 6'd5, 32'h00000000);
    applyStimulus(3'b010, 6'd5, 32'h0BADF00D);
    checkLoad("store_after_release", 1'b1, 3'b010, 6'd5, 32'h0BADF00D);

    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 64; i++) modelMem[i] = 32'd0;
    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ad = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        applyStimulus(f3, ad, d);
        case (f3)
          3'b000: modelMem[ad][7:0]  = d[7:0];
          3'b001: modelMem[ad][15:0] = d[15:0];
          3'b010: modelMem[ad]       = d;
          default: ;
        endcase
      end else begin
        rd = ($urandom_range(0, 7) != 0);
        checkLoad("rnd_load", rd, f3, ad, refLoad(rd, f3, modelMem[ad]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
